// File: rtl/key_event_pkg.sv
// Shared constants for the key event decoder: default ASCII key map,
// default pulse/lockout lengths and the per-channel counter widths.
package key_event_pkg;

  localparam logic [7:0] KEY_W     = 8'h77;
  localparam logic [7:0] KEY_S     = 8'h73;
  localparam logic [7:0] KEY_A     = 8'h61;
  localparam logic [7:0] KEY_D     = 8'h64;
  localparam logic [7:0] KEY_SPACE = 8'h20;
  localparam logic [7:0] KEY_ENTER = 8'h0D;

  // Channel 0 sits in the low byte.
  localparam logic [47:0] KEY_CODES_DEF = {KEY_ENTER, KEY_SPACE, KEY_D, KEY_A, KEY_S, KEY_W};

  localparam int HOLD_DEF = 1000;
  localparam int CD_DEF   = 500000;

  localparam int HOLD_CNT_W = 16;
  localparam int CD_CNT_W   = 20;

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous event FIFO. Pointers carry one extra wrap bit so
// full/empty come from comparing MSBs. A push into a full FIFO is only
// taken when a pop happens in the same cycle. The head output reads as
// zero while empty so it has a defined value out of reset.
module key_evt_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; data is not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/key_event_decoder.sv
// Maps UART bytes onto NUM_KEYS key channels. Each channel gets a
// stretched hold pulse plus a re-trigger cooldown, and each accepted
// press is queued in an event FIFO for the game FSM.
// Optional: define KEY_CASE_FOLD_EN to fold 'A'..'Z' to lower case
// before matching.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS        = 6,
  parameter int DATA_W          = 8,
  parameter logic [NUM_KEYS*DATA_W-1:0] KEY_CODES = KEY_CODES_DEF,
  parameter int HOLD_CYCLES     = HOLD_DEF,
  parameter int COOLDOWN_CYCLES = CD_DEF,
  parameter int EVT_DEPTH       = 4,
  localparam int IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_idx,
  input  logic                evt_ready,
  output logic [7:0]          drop_cnt
);

  function automatic logic [DATA_W-1:0] fold_case(input logic [DATA_W-1:0] b);
    if (b >= DATA_W'(8'h41) && b <= DATA_W'(8'h5A)) return b + DATA_W'(8'h20);
    return b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                rx_vld_p0;
  logic                accept;
  logic [DATA_W-1:0]   match_byte;
  logic                match_hit;
  logic [IDX_W-1:0]    match_idx;
  logic [NUM_KEYS-1:0] cd_zero;
  logic [NUM_KEYS-1:0] trig_vec;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;

`ifdef KEY_CASE_FOLD_EN
  assign match_byte = fold_case(rx_data);
`else
  assign match_byte = rx_data;
`endif

  // Delay flop for rising-edge detection of rx_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_vld_p0 <= 1'b0;
    else          rx_vld_p0 <= rx_valid;
  end

  assign accept = rx_valid && !rx_vld_p0;

  // Parallel match; scanning downward lets the lowest index win on duplicates.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (match_byte == KEY_CODES[DATA_W*i +: DATA_W]) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [CD_CNT_W-1:0]   cd_cnt;

    assign cd_zero[g]  = (cd_cnt == '0);
    assign trig_vec[g] = accept && match_hit && (match_idx == IDX_W'(g)) && cd_zero[g];
    assign key_hold[g] = (hold_cnt != '0);

    // Load on trigger, otherwise count both timers down to zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_cnt <= '0;
        cd_cnt   <= '0;
      end else if (trig_vec[g]) begin
        hold_cnt <= HOLD_CNT_W'(HOLD_CYCLES);
        cd_cnt   <= CD_CNT_W'(COOLDOWN_CYCLES);
      end else begin
        if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
        if (cd_cnt != '0)   cd_cnt   <= cd_cnt - CD_CNT_W'(1);
      end
    end
  end

  // Edge detection guarantees at most one bit of trig_vec is set, so
  // match_idx is the index of the triggering channel.
  assign push      = |trig_vec;
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign drop      = push && fifo_full && !pop;

  key_evt_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (EVT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (match_idx),
    .pop       (pop),
    .pop_data  (evt_idx),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Saturating count of presses lost to a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  drop_cnt <= 8'd0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with shortened hold/cooldown.
module tb_key_event_decoder;

  localparam int HOLD = 20;
  localparam int CD   = 60;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [5:0] key_hold;
  logic       evt_valid;
  logic [2:0] evt_idx;
  logic       evt_ready;
  logic [7:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_event_decoder #(
    .NUM_KEYS        (6),
    .DATA_W          (8),
    .KEY_CODES       (48'h0D_20_64_61_73_77),
    .HOLD_CYCLES     (HOLD),
    .COOLDOWN_CYCLES (CD),
    .EVT_DEPTH       (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_hold  (key_hold),
    .evt_valid (evt_valid),
    .evt_idx   (evt_idx),
    .evt_ready (evt_ready),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle rx_valid strobe; returns at the negedge right after the accept edge.
  task automatic press(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    evt_ready = 1'b0;
    idle(3);
    chk("rst_hold",  32'(key_hold), 32'h0);
    chk("rst_valid", 32'(evt_valid), 32'h0);
    chk("rst_idx",   32'(evt_idx), 32'h0);
    chk("rst_drop",  32'(drop_cnt), 32'h0);
    reset_n = 1'b1;
    idle(2);

    // Single 'w' press: pulse length and event
    press(8'h77);
    chk("w_hold_start", 32'(key_hold), 32'h01);
    chk("w_evt_valid",  32'(evt_valid), 32'h1);
    chk("w_evt_idx",    32'(evt_idx), 32'h0);
    idle(HOLD - 1);
    chk("w_hold_last",  32'(key_hold), 32'h01);
    idle(1);
    chk("w_hold_end",   32'(key_hold), 32'h00);
    pop_one();
    chk("w_popped",     32'(evt_valid), 32'h0);

    // Level held longer than the cooldown must give one trigger only
    @(negedge clk);
    rx_data  = 8'h61;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("lvl_hold",  32'(key_hold), 32'h04);
    chk("lvl_idx",   32'(evt_idx), 32'h2);
    idle(CD + 19);
    rx_valid = 1'b0;
    chk("lvl_hold_off", 32'(key_hold), 32'h00);
    pop_one();
    chk("lvl_one_evt",  32'(evt_valid), 32'h0);
    idle(CD + 10);

    // Cooldown: second 's' inside lockout ignored, later press accepted
    press(8'h73);
    chk("s1_hold", 32'(key_hold), 32'h02);
    chk("s1_idx",  32'(evt_idx), 32'h1);
    pop_one();
    idle(27);
    press(8'h73);
    chk("s2_hold",  32'(key_hold), 32'h00);
    chk("s2_valid", 32'(evt_valid), 32'h0);
    chk("s2_drop",  32'(drop_cnt), 32'h0);
    idle(40);
    press(8'h73);
    chk("s3_hold", 32'(key_hold), 32'h02);
    chk("s3_idx",  32'(evt_idx), 32'h1);
    pop_one();
    chk("s3_popped", 32'(evt_valid), 32'h0);
    idle(CD + 10);

    // Fill the FIFO with w,s,a,d; space is dropped but still pulses
    press(8'h77);
    press(8'h73);
    press(8'h61);
    press(8'h64);
    press(8'h20);
    chk("full_space_hold", 32'(key_hold[4]), 32'h1);
    chk("full_drop",  32'(drop_cnt), 32'h1);
    chk("full_valid", 32'(evt_valid), 32'h1);
    chk("full_head",  32'(evt_idx), 32'h0);

    // Enter pressed in the same cycle as a pop: accepted, no drop
    @(negedge clk);
    rx_data   = 8'h0D;
    rx_valid  = 1'b1;
    evt_ready = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    evt_ready = 1'b0;
    chk("pp_drop",  32'(drop_cnt), 32'h1);
    chk("pp_enter", 32'(key_hold[5]), 32'h1);
    chk("drain0", 32'(evt_idx), 32'h1);
    pop_one();
    chk("drain1", 32'(evt_idx), 32'h2);
    pop_one();
    chk("drain2", 32'(evt_idx), 32'h3);
    pop_one();
    chk("drain3", 32'(evt_idx), 32'h5);
    chk("drain3_valid", 32'(evt_valid), 32'h1);
    pop_one();
    chk("drain_empty", 32'(evt_valid), 32'h0);
    idle(CD + 10);

    // Unmatched byte: no effect
    press(8'h55);
    chk("nomatch_hold",  32'(key_hold), 32'h00);
    chk("nomatch_valid", 32'(evt_valid), 32'h0);

    // Upper-case 'A'
    press(8'h41);
`ifdef KEY_CASE_FOLD_EN
    chk("fold_hold", 32'(key_hold), 32'h04);
    chk("fold_idx",  32'(evt_idx), 32'h2);
    pop_one();
`else
    chk("nofold_hold",  32'(key_hold), 32'h00);
    chk("nofold_valid", 32'(evt_valid), 32'h0);
`endif
    idle(5);

    // Mid-pulse reset with FIFO non-empty and drop_cnt nonzero
    press(8'h64);
    idle(5);
    chk("pre_rst_hold", 32'(key_hold), 32'h08);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hold",  32'(key_hold), 32'h00);
    chk("mid_rst_valid", 32'(evt_valid), 32'h0);
    chk("mid_rst_drop",  32'(drop_cnt), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    press(8'h64);
    chk("post_rst_hold", 32'(key_hold), 32'h08);
    chk("post_rst_idx",  32'(evt_idx), 32'h3);
    chk("post_rst_valid", 32'(evt_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Parametrised successor to the fixed WASD/space/enter UART key decoder. It maps received bytes onto NUM_KEYS configurable key channels. Each channel has a stretched hold pulse and its own cooldown. Every accepted keypress is also posted into a small event FIFO with ready/valid pop, so the game FSM can consume presses without losing them. Sits between uart_rx and the TTT control FSM.

Parameters:
NUM_KEYS, 6, number of key channels (1..16)
DATA_W, 8, received byte width
KEY_CODES, 48'h0D_20_64_61_73_77, packed codes; channel i = KEY_CODES[DATA_W*i +: DATA_W]; default idx0 'w', 1 's', 2 'a', 3 'd', 4 space, 5 enter
HOLD_CYCLES, 1000, hold-pulse length in clocks (>=1, fits 16 bits)
COOLDOWN_CYCLES, 500000, per-channel re-trigger lockout (fits 20 bits)
EVT_DEPTH, 4, event FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx_data  in  DATA_W  byte from UART receiver
rx_valid  in  1  byte-valid level/strobe from receiver
key_hold  out  NUM_KEYS  per-channel stretched press pulse
evt_valid  out  1  event FIFO non-empty
evt_idx  out  $clog2(NUM_KEYS) (min 1)  channel index at FIFO head
evt_ready  in  1  consumer pops head when evt_valid & evt_ready
drop_cnt  out  8  saturating count of events lost to a full FIFO

Behaviour:
- Reset (async, reset_n=0): key_hold=0, evt_valid=0, evt_idx=0, drop_cnt=0. Every hold counter, cooldown counter, FIFO pointer and the rx_valid delay flop is cleared. Mid-operation reset aborts pulses and flushes the FIFO immediately.
- Accept: rx_valid is registered. A byte is sampled on cycle T when rx_valid=1 and the delayed copy is 0 (rising edge). A level held high yields exactly one accept.
- Match: rx_data is compared with all KEY_CODES in parallel. If codes are duplicated, the lowest index wins. A byte matching no channel is ignored, with no state change.
- Trigger: on a match to channel i with cd_cnt[i]==0, hold_cnt[i] loads HOLD_CYCLES and cd_cnt[i] loads COOLDOWN_CYCLES at the T edge. If cd_cnt[i]!=0, the press is discarded silently: no pulse, no event, no drop count.
- key_hold[i] = (hold_cnt[i]!=0), decoded from the register. It is high for exactly HOLD_CYCLES cycles, T+1..T+HOLD_CYCLES.
- Every cycle, each nonzero hold_cnt and cd_cnt decrements by 1, saturating at 0. On a load cycle the load wins over the decrement.
- If COOLDOWN_CYCLES < HOLD_CYCLES, a re-trigger during hold reloads hold_cnt, extending the pulse.
- Event push: each trigger pushes index i in the same cycle.
  - FIFO not full: push accepted; evt_valid rises at T+1.
  - FIFO full and no pop this cycle: event dropped; drop_cnt increments, saturating at 255; key_hold still fires.
  - Full with a simultaneous pop: push accepted, no drop.
- Pop: evt_valid & evt_ready advances the head. Pop on empty is impossible because evt_valid=0. evt_idx is valid only while evt_valid=1; its value otherwise is don't-care.
- FIFO order is strict FIFO. Pointers are (log2(EVT_DEPTH)+1) bits wide, wrap-around, full/empty from MSB compare.
- At most one trigger per cycle, which follows from edge detection.

Optional Feature:
KEY_CASE_FOLD_EN
- Defined: before matching, bytes 8'h41..8'h5A are mapped +8'h20, so 'W' triggers the 'w' channel. The fold applies to rx_data only, not KEY_CODES.
- Undefined: exact byte match only; 'W' (8'h57) is ignored under the default map.

Decomposition:
- Package key_event_pkg: default ASCII code constants (KEY_W/S/A/D/SPACE/ENTER), default KEY_CODES vector, hold/cooldown defaults, counter width localparams (16, 20).
- Sub-module key_evt_fifo: synchronous FIFO parametrised by width and depth, with push/pop/full/empty outputs. The top level holds the edge detect, matcher, per-channel counter generate loop and drop counter.

Test Plan:
- Reset then rx_data=8'h77 with rx_valid pulsed 1 cycle at T -> key_hold[0] high T+1..T+1000, evt_valid=1 and evt_idx=0 at T+1; pop -> evt_valid=0.
- rx_valid held high 50 cycles with 8'h61 -> exactly one trigger on key_hold[2]; one event.
- Two 8'h73 presses 1000 cycles apart -> second ignored (cooldown), no event, drop_cnt=0; third press at T+500000 -> pulse and event.
- evt_ready=0, presses w,s,a,d,space (distinct channels) -> FIFO holds 0,1,2,3; drop_cnt=1; drain gives order 0,1,2,3.
- Full FIFO, press enter in the same cycle as a pop -> no drop, last entry idx 5; 8'h41 with KEY_CASE_FOLD_EN -> idx 2, without -> ignored.
- Assert reset_n mid-pulse with the FIFO non-empty -> key_hold=0, evt_valid=0 and drop_cnt=0 immediately; next press triggers normally (cooldown cleared).
